// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared state encodings and default stage indices for the pipeline hazard controller.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MC_BUSY  = 2'd1,
    ST_REDIRECT = 2'd2
  } ctrl_state_e;

  localparam int STAGE_IF  = 0;
  localparam int STAGE_ID  = 1;
  localparam int STAGE_EX  = 2;
  localparam int STAGE_MEM = 3;
  localparam int STAGE_WB  = 4;

  localparam int DEF_NUM_STAGES = STAGE_WB + 1;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard event inputs and per-stage stall/flush outputs between the pipeline and its controller.
interface pipeline_hazard_ctrl_if #(
  parameter int NUM_STAGES = 5,
  parameter int MC_W       = 4
);
  logic                  branch_valid;
  logic                  branch_taken;
  logic                  branch_prediction;
  logic                  load_use_hazard;
  logic                  mc_start;
  logic [MC_W-1:0]       mc_latency;
  logic                  trap_req;
  logic                  redirect_ready;
  logic [NUM_STAGES-1:0] stall;
  logic [NUM_STAGES-1:0] flush;
  logic                  redirect_valid;

  modport master (
    output branch_valid, branch_taken, branch_prediction, load_use_hazard,
           mc_start, mc_latency, trap_req, redirect_ready,
    input  stall, flush, redirect_valid
  );

  modport slave (
    input  branch_valid, branch_taken, branch_prediction, load_use_hazard,
           mc_start, mc_latency, trap_req, redirect_ready,
    output stall, flush, redirect_valid
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous reset; used for the hazard performance counters.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);
  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else if (inc && (count_reg != '1)) begin
      count_reg <= count_reg + WIDTH'(1);
    end
  end

  assign count = count_reg;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: turns branch, load-use, multicycle and trap events into
// per-stage stall/flush, tracks a RUN / MC_BUSY / REDIRECT FSM and two perf counters.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int NUM_STAGES = DEF_NUM_STAGES,
  parameter int EX_STAGE   = STAGE_EX,
  parameter int MC_W       = 4,
  parameter int PERF_W     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  pipeline_hazard_ctrl_if.slave bus,
  output logic [1:0]            state,
  output logic [PERF_W-1:0]     mispredict_cnt,
  output logic [PERF_W-1:0]     stall_cycles
);

  ctrl_state_e           state_reg, state_next;
  logic [MC_W-1:0]       mc_cnt_reg, mc_cnt_next;
  logic [NUM_STAGES-1:0] stall_raw, flush_raw, stall_out;
  logic [NUM_STAGES-1:0] front_mask, trap_mask, ex_mask, post_ex_mask, live_mask;
  logic                  redirect_raw, mispredict_hit;

  // Constant stage masks: front = IF..EX, trap = IF..MEM-side (all but WB).
  genvar gi;
  generate
    for (gi = 0; gi < NUM_STAGES; gi++) begin : g_stage_mask
      assign front_mask[gi]   = (gi <= EX_STAGE);
      assign trap_mask[gi]    = (gi <= NUM_STAGES - 2);
      assign ex_mask[gi]      = (gi == EX_STAGE);
      assign post_ex_mask[gi] = (gi == EX_STAGE + 1);
      assign live_mask[gi]    = (gi < NUM_STAGES - 1);
    end
  endgenerate

  always_comb begin
    stall_raw      = '0;
    flush_raw      = '0;
    redirect_raw   = 1'b0;
    mispredict_hit = 1'b0;
    state_next     = state_reg;
    mc_cnt_next    = mc_cnt_reg;

    case (state_reg)
      ST_MC_BUSY: begin
        stall_raw   = front_mask;
        flush_raw   = post_ex_mask;
        mc_cnt_next = mc_cnt_reg - MC_W'(1);
        if (mc_cnt_reg <= MC_W'(1)) begin
          state_next = ST_RUN;
        end
      end
      ST_REDIRECT: begin
        redirect_raw = 1'b1;
        stall_raw[0] = 1'b1;
        flush_raw[1] = 1'b1;
        if (bus.redirect_ready) begin
          state_next = ST_RUN;
        end
      end
      default: begin
        // Encoding 3 is unreachable and falls through to RUN behaviour.
        mispredict_hit = bus.branch_valid && (bus.branch_taken != bus.branch_prediction);
        if (mispredict_hit) begin
          flush_raw = front_mask;
        end else begin
          if (bus.load_use_hazard) begin
            stall_raw[1:0] = 2'b11;
            flush_raw      = ex_mask;
          end
          if (bus.mc_start && (bus.mc_latency[MC_W-1:1] != '0)) begin
            mc_cnt_next = bus.mc_latency - MC_W'(1);
            state_next  = ST_MC_BUSY;
          end
        end
      end
    endcase

    // A trap overrides everything, including a mispredict in the same cycle.
    if (bus.trap_req) begin
      stall_raw      = '0;
      flush_raw      = trap_mask;
      mc_cnt_next    = '0;
      mispredict_hit = 1'b0;
      state_next     = ST_REDIRECT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= ST_RUN;
      mc_cnt_reg <= '0;
    end else begin
      state_reg  <= state_next;
      mc_cnt_reg <= mc_cnt_next;
    end
  end

  assign stall_out          = reset ? '0 : (stall_raw & live_mask);
  assign bus.stall          = stall_out;
  assign bus.flush          = reset ? '0 : (flush_raw & live_mask);
  assign bus.redirect_valid = reset ? 1'b0 : redirect_raw;
  assign state              = state_reg;

  sat_counter #(.WIDTH(PERF_W)) u_mispredict_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (mispredict_hit),
    .count (mispredict_cnt)
  );

  sat_counter #(.WIDTH(PERF_W)) u_stall_cycles (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_out[0]),
    .count (stall_cycles)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a default instance and a PERF_W=4 instance share
// stimulus; a behavioural model checks every cycle and literal expectations pin key points.
module tb_pipeline_hazard_ctrl;
  localparam int NS      = 5;
  localparam int EX      = 2;
  localparam int M_FRONT = (1 << (EX + 1)) - 1;
  localparam int M_TRAP  = (1 << (NS - 1)) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.NUM_STAGES(NS), .MC_W(4)) bus_a ();
  pipeline_hazard_ctrl_if #(.NUM_STAGES(NS), .MC_W(4)) bus_b ();

  logic [1:0]  state_a, state_b;
  logic [15:0] misp_a, sc_a;
  logic [3:0]  misp_b, sc_b;

  assign bus_b.branch_valid      = bus_a.branch_valid;
  assign bus_b.branch_taken      = bus_a.branch_taken;
  assign bus_b.branch_prediction = bus_a.branch_prediction;
  assign bus_b.load_use_hazard   = bus_a.load_use_hazard;
  assign bus_b.mc_start          = bus_a.mc_start;
  assign bus_b.mc_latency        = bus_a.mc_latency;
  assign bus_b.trap_req          = bus_a.trap_req;
  assign bus_b.redirect_ready    = bus_a.redirect_ready;

  pipeline_hazard_ctrl u_dut (
    .clk(clk), .reset(reset), .bus(bus_a), .state(state_a),
    .mispredict_cnt(misp_a), .stall_cycles(sc_a)
  );

  pipeline_hazard_ctrl #(.PERF_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .bus(bus_b), .state(state_b),
    .mispredict_cnt(misp_b), .stall_cycles(sc_b)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: 0 = RUN, 1 = MC_BUSY, 2 = REDIRECT; m_left = MC_BUSY cycles still owed.
  int m_state = 0, m_left = 0;
  int m_misp_a = 0, m_misp_b = 0, m_sc_a = 0, m_sc_b = 0;

  always @(negedge clk) begin
    int es, ef, erv;
    bit misp;
    es = 0; ef = 0; erv = 0; misp = 1'b0;
    if (reset) begin
      es = 0;
    end else if (bus_a.trap_req) begin
      ef  = M_TRAP;
      erv = (m_state == 2) ? 1 : 0;
    end else if (m_state == 2) begin
      erv = 1; es = 1; ef = 2;
    end else if (m_state == 1) begin
      es = M_FRONT; ef = 1 << (EX + 1);
    end else begin
      misp = bus_a.branch_valid && (bus_a.branch_taken != bus_a.branch_prediction);
      if (misp) ef = M_FRONT;
      else if (bus_a.load_use_hazard) begin
        es = 3; ef = 1 << EX;
      end
    end

    check("cyc_stall",  32'(bus_a.stall), 32'(es));
    check("cyc_flush",  32'(bus_a.flush), 32'(ef));
    check("cyc_rv",     32'(bus_a.redirect_valid), 32'(erv));
    check("cyc_state",  32'(state_a), 32'(m_state));
    check("cyc_misp",   32'(misp_a), 32'(m_misp_a));
    check("cyc_sc",     32'(sc_a), 32'(m_sc_a));
    check("cyc_stall4", 32'(bus_b.stall), 32'(es));
    check("cyc_misp4",  32'(misp_b), 32'(m_misp_b));
    check("cyc_sc4",    32'(sc_b), 32'(m_sc_b));

    if (reset) begin
      m_state = 0; m_left = 0;
      m_misp_a = 0; m_misp_b = 0; m_sc_a = 0; m_sc_b = 0;
    end else begin
      if (misp) begin
        if (m_misp_a < 65535) m_misp_a++;
        if (m_misp_b < 15)    m_misp_b++;
      end
      if ((es & 1) != 0) begin
        if (m_sc_a < 65535) m_sc_a++;
        if (m_sc_b < 15)    m_sc_b++;
      end
      if (bus_a.trap_req) begin
        m_state = 2; m_left = 0;
      end else if (m_state == 2) begin
        if (bus_a.redirect_ready) m_state = 0;
      end else if (m_state == 1) begin
        m_left--;
        if (m_left == 0) m_state = 0;
      end else if (!misp && bus_a.mc_start && (bus_a.mc_latency >= 2)) begin
        m_state = 1;
        m_left  = int'(bus_a.mc_latency) - 1;
      end
    end
  end

  task automatic step(input bit bv, input bit bt, input bit bp, input bit luh, input bit mcs,
                      input int lat, input bit trap, input bit rdy, input bit rst);
    @(posedge clk);
    #1;
    reset                   = rst;
    bus_a.branch_valid      = bv;
    bus_a.branch_taken      = bt;
    bus_a.branch_prediction = bp;
    bus_a.load_use_hazard   = luh;
    bus_a.mc_start          = mcs;
    bus_a.mc_latency        = 4'(lat);
    bus_a.trap_req          = trap;
    bus_a.redirect_ready    = rdy;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  int sc0;

  initial begin
    reset = 1'b1;
    bus_a.branch_valid = 0; bus_a.branch_taken = 0; bus_a.branch_prediction = 0;
    bus_a.load_use_hazard = 0; bus_a.mc_start = 0; bus_a.mc_latency = 0;
    bus_a.trap_req = 0; bus_a.redirect_ready = 0;

    // Reset with every hazard input active: outputs must stay quiet.
    step(1, 1, 0, 1, 1, 4, 1, 1, 1); #2;
    check("rst_stall", 32'(bus_a.stall), 32'h0);
    check("rst_flush", 32'(bus_a.flush), 32'h0);
    check("rst_rv",    32'(bus_a.redirect_valid), 32'h0);
    idle(); #2;
    check("rst_state", 32'(state_a), 32'h0);
    check("rst_misp",  32'(misp_a), 32'h0);

    // Plain mispredict.
    step(1, 1, 0, 0, 0, 0, 0, 0, 0); #2;
    check("misp_flush", 32'(bus_a.flush), 32'b00111);
    check("misp_stall", 32'(bus_a.stall), 32'h0);
    idle(); #2;
    check("misp_cnt1", 32'(misp_a), 32'd1);

    // Correct prediction and an unqualified outcome do nothing.
    step(1, 1, 1, 0, 0, 0, 0, 0, 0); #2;
    check("hit_flush", 32'(bus_a.flush), 32'h0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0); #2;
    check("nobv_flush", 32'(bus_a.flush), 32'h0);

    // Mispredict beats load-use.
    step(1, 0, 1, 1, 0, 0, 0, 0, 0); #2;
    check("luh_misp_flush", 32'(bus_a.flush), 32'b00111);
    check("luh_misp_stall", 32'(bus_a.stall), 32'h0);

    // Load-use alone.
    step(0, 0, 0, 1, 0, 0, 0, 0, 0); #2;
    check("luh_stall", 32'(bus_a.stall), 32'b00011);
    check("luh_flush", 32'(bus_a.flush), 32'b00100);

    // Multicycle op, latency 4; events during MC_BUSY are ignored.
    step(0, 0, 0, 0, 1, 4, 0, 0, 0); #2;
    sc0 = int'(sc_a);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 1, 1, 9, 0, 0, 0); #2;
      check("mc_state", 32'(state_a), 32'd1);
      check("mc_stall", 32'(bus_a.stall), 32'b00111);
      check("mc_flush", 32'(bus_a.flush), 32'b01000);
    end
    idle(); #2;
    check("mc_done_state", 32'(state_a), 32'd0);
    check("mc_stall_cycles", 32'(sc_a), 32'(sc0 + 3));
    check("mc_misp_ignored", 32'(misp_a), 32'd2);

    // Latency 1 and 0 never leave RUN.
    step(0, 0, 0, 0, 1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0, 0); #2;
    check("lat1_state", 32'(state_a), 32'd0);
    idle(); #2;
    check("lat0_state", 32'(state_a), 32'd0);

    // Trap in the second MC_BUSY cycle, then a slow redirect handshake.
    step(0, 0, 0, 0, 1, 5, 0, 0, 0);
    idle(); #2;
    check("trap_pre_state", 32'(state_a), 32'd1);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0); #2;
    check("trap_flush", 32'(bus_a.flush), 32'b01111);
    check("trap_stall", 32'(bus_a.stall), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 0, 0, 0, 0); #2;
      check("redir_state", 32'(state_a), 32'd2);
      check("redir_rv",    32'(bus_a.redirect_valid), 32'd1);
      check("redir_stall", 32'(bus_a.stall), 32'b00001);
      check("redir_flush", 32'(bus_a.flush), 32'b00010);
    end
    step(0, 0, 0, 0, 0, 0, 0, 1, 0); #2;
    check("redir_acc_rv", 32'(bus_a.redirect_valid), 32'd1);
    idle(); #2;
    check("redir_done_state", 32'(state_a), 32'd0);
    check("redir_done_rv",    32'(bus_a.redirect_valid), 32'd0);

    // Trap re-applied in REDIRECT outranks redirect_ready.
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 1, 0); #2;
    check("retrap_flush", 32'(bus_a.flush), 32'b01111);
    check("retrap_rv",    32'(bus_a.redirect_valid), 32'd1);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0); #2;
    check("retrap_state", 32'(state_a), 32'd2);
    idle(); #2;
    check("retrap_done", 32'(state_a), 32'd0);

    // Twenty mispredicts saturate the 4-bit counter.
    for (int i = 0; i < 20; i++) step(1, i[0], ~i[0], 0, 0, 0, 0, 0, 0);
    idle(); #2;
    check("sat_misp4", 32'(misp_b), 32'd15);
    check("sat_misp16", 32'(misp_a), 32'd22);

    // Reset in the middle of MC_BUSY.
    step(0, 0, 0, 0, 1, 8, 0, 0, 0);
    idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 1); #2;
    check("rst_mc_stall", 32'(bus_a.stall), 32'h0);
    idle(); #2;
    check("rst_mc_state", 32'(state_a), 32'd0);
    check("rst_mc_misp",  32'(misp_a), 32'd0);

    // Reset in REDIRECT with a trap still raised.
    step(1, 0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 1); #2;
    check("rst_redir_stall", 32'(bus_a.stall), 32'h0);
    check("rst_redir_flush", 32'(bus_a.flush), 32'h0);
    check("rst_redir_rv",    32'(bus_a.redirect_valid), 32'h0);
    idle(); #2;
    check("rst_redir_state", 32'(state_a), 32'd0);
    check("rst_redir_misp",  32'(misp_a), 32'd0);
    check("rst_redir_sc",    32'(sc_a), 32'd0);

    step(0, 0, 0, 1, 0, 0, 0, 0, 0);
    idle(); #2;
    check("post_rst_sc", 32'(sc_a), 32'd1);
    idle();
    #2;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter NUM_STAGES, default 5, pipeline depth; stage 0 = IF, stage NUM_STAGES-1 = WB; legal range 4..8.
REQ-002 Parameter EX_STAGE, default 2, index of the stage that resolves branches and hosts multicycle ops; legal range 1..NUM_STAGES-3.
REQ-003 Parameter MC_W, default 4, width of the multicycle latency input.
REQ-004 Parameter PERF_W, default 16, width of each performance counter.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 branch_valid  in  1  branch resolved in EX this cycle.
REQ-008 branch_taken  in  1  actual outcome, qualified by branch_valid.
REQ-009 branch_prediction  in  1  predicted outcome, qualified by branch_valid.
REQ-010 load_use_hazard  in  1  load-use dependency detected in ID.
REQ-011 mc_start  in  1  multicycle op (mul/div) entering EX this cycle.
REQ-012 mc_latency  in  MC_W  total EX occupancy in cycles, sampled with mc_start.
REQ-013 trap_req  in  1  exception/interrupt raised at the MEM stage.
REQ-014 redirect_ready  in  1  fetch unit accepts the trap redirect.
REQ-015 stall  out  NUM_STAGES  per-stage hold; bit i holds stage i.
REQ-016 flush  out  NUM_STAGES  per-stage kill; bit i turns stage i into a bubble.
REQ-017 redirect_valid  out  1  trap redirect pending.
REQ-018 state  out  2  current FSM state encoding.
REQ-019 mispredict_cnt  out  PERF_W  count of accepted mispredictions.
REQ-020 stall_cycles  out  PERF_W  count of cycles with stall[0]=1.

Function
REQ-021 The FSM SHALL have states RUN=0, MC_BUSY=1, REDIRECT=2; encoding 3 is unreachable and decodes as RUN.
REQ-022 Mispredict SHALL be defined as branch_valid & (branch_taken != branch_prediction), evaluated only in RUN.
REQ-023 In RUN, a mispredict SHALL assert flush[0..EX_STAGE] in the same cycle, clear all stall bits, and increment mispredict_cnt.
REQ-024 In RUN, a load_use_hazard without mispredict SHALL assert stall[0..1] and flush[EX_STAGE] (bubble) in the same cycle.
REQ-025 In RUN, mc_start with mc_latency of L >= 2 and no mispredict SHALL load a counter with L-1 and enter MC_BUSY next cycle; L of 0 or 1 SHALL cause no state change.
REQ-026 In MC_BUSY, the block SHALL assert stall[0..EX_STAGE] and flush[EX_STAGE+1] every cycle, decrement the counter, and return to RUN after the cycle in which the counter equals 1, giving exactly L-1 MC_BUSY cycles.
REQ-027 branch_valid, load_use_hazard and mc_start SHALL be ignored in MC_BUSY and REDIRECT.
REQ-028 trap_req SHALL have highest priority in every state: flush[0..NUM_STAGES-2] asserted that cycle, stall cleared, counter cleared, next state REDIRECT.
REQ-029 In REDIRECT, the block SHALL assert redirect_valid=1, stall[0]=1 and flush[1]=1 every cycle.
REQ-030 In REDIRECT, redirect_valid & redirect_ready SHALL return the FSM to RUN next cycle; redirect_valid SHALL not drop before acceptance.
REQ-031 trap_req in REDIRECT SHALL re-apply the REQ-028 flush and remain in REDIRECT, even if redirect_ready=1 that cycle.
REQ-032 stall[NUM_STAGES-1] and flush[NUM_STAGES-1] SHALL always be 0, so WB never stalls or is killed.
REQ-033 Both counters SHALL saturate at 2^PERF_W-1 and never wrap.
REQ-034 stall_cycles SHALL increment on every non-reset cycle with stall[0]=1.

Reset
REQ-035 While reset=1, stall, flush and redirect_valid SHALL be forced to 0, regardless of inputs.
REQ-036 On a clock edge with reset=1, the state SHALL become RUN and the counter and both perf counters SHALL become 0, including when reset lands mid-MC_BUSY or mid-REDIRECT.

Structure
REQ-037 Package pipeline_ctrl_pkg SHALL hold the state encodings and the default stage indices (IF/ID/EX/MEM/WB).
REQ-038 One sub-module, sat_counter (parametrised width, synchronous reset, increment enable), SHALL implement both perf counters.
REQ-039 Outputs stall, flush and redirect_valid SHALL be combinational from the state and the current inputs; the state and counters SHALL be registered.

Verification
REQ-040 Defaults; branch_valid=1, taken=1, prediction=0 in RUN -> flush=5'b00111, stall=0, mispredict_cnt 0->1.
REQ-041 load_use_hazard=1 and mispredict in the same cycle -> flush=5'b00111, stall=0 (mispredict wins).
REQ-042 mc_start=1 with mc_latency=4 -> next 3 cycles state=MC_BUSY, stall=5'b00111, flush=5'b01000; state=RUN on the 4th cycle; stall_cycles +3.
REQ-043 trap_req during the 2nd MC_BUSY cycle -> flush=5'b01111 that cycle; then REDIRECT with redirect_valid=1; redirect_ready held 0 for 3 cycles then 1 -> RUN one cycle later.
REQ-044 PERF_W=4, 20 consecutive mispredicts -> mispredict_cnt holds at 15.
REQ-045 reset=1 asserted in REDIRECT with trap_req=1 -> stall=flush=0 and redirect_valid=0 that cycle; state=RUN and counters 0 after the edge.
